bit_serializer_piso: RTL and testbench

//   Parallel-in/serial-out stage directly upstream of the serial pattern detectors.

---
 rtl/bit_serializer_piso.sv | 150 +++++++++++++++
 tb/tb_bit_serializer_piso.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_serializer_piso.sv
`default_nettype none
// ============================================================================
//  Module   : bit_serializer_piso
//  Brief    : Parallel-in / serial-out stage feeding the serial pattern
//             detectors. Accepts WIDTH-bit words over valid/ready and emits
//             one bit per consumed cycle. A one-word holding register lets
//             back-to-back words stream with no bubble bits between them.
//  Revision : 1.0 - initial release
// ============================================================================
module bit_serializer_piso #(
    parameter int WIDTH     = 8,     // word width in bits, must be >= 2
    parameter bit MSB_FIRST = 1'b1   // 1: bit WIDTH-1 leaves first, 0: bit 0 first
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    input  logic             bit_en,
    output logic             bit_out,
    output logic             bit_valid,
    output logic             word_done,
    output logic             busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int c_cnt_w = $clog2(WIDTH);

    // Index of the final bit of a word; consuming it ends the word.
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(WIDTH - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);

    // FSM encoding: IDLE means the shifter is empty, SHIFT means it holds a word.
    localparam logic [0:0] c_st_idle  = 1'b0;
    localparam logic [0:0] c_st_shift = 1'b1;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [0:0]         r_state;
    logic [WIDTH-1:0]   r_shift;      // word currently being serialised
    logic [WIDTH-1:0]   r_hold;       // next word, parked while the shifter is busy
    logic               r_hold_full;
    logic [c_cnt_w-1:0] r_bit_cnt;    // index of the bit now presented on bit_out

    // ------------------------------------------------------------------------
    // Combinational decode
    // ------------------------------------------------------------------------
    logic             w_xfer;         // a word is accepted this cycle
    logic             w_shifting;     // shifter holds a word
    logic             w_consume;      // downstream takes the current bit
    logic             w_last;         // the bit taken is the last of the word
    logic             w_head;         // bit presented on the serial output
    logic [WIDTH-1:0] w_shift_next;   // shifter after one bit has been taken

    // Ready depends only on the holding register, never on this cycle's
    // consume, so there is no combinational path from bit_en to din_ready.
    assign din_ready  = ~r_hold_full;
    assign w_xfer     = din_valid & din_ready;
    assign w_shifting = (r_state == c_st_shift);
    assign w_consume  = w_shifting & bit_en;
    assign w_last     = w_consume & (r_bit_cnt == c_last_cnt);

    // Bit order is fixed at elaboration: only the tap point and shift
    // direction differ between the two orders.
    generate
        if (MSB_FIRST) begin : g_msb_first
            assign w_head       = r_shift[WIDTH-1];
            assign w_shift_next = {r_shift[WIDTH-2:0], 1'b0};
        end else begin : g_lsb_first
            assign w_head       = r_shift[0];
            assign w_shift_next = {1'b0, r_shift[WIDTH-1:1]};
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bit_valid = w_shifting;
    assign bit_out   = w_shifting & w_head;   // forced low while nothing is valid
    assign word_done = w_last;
    assign busy      = w_shifting | r_hold_full;

    // ------------------------------------------------------------------------
    // Sequential logic
    // ------------------------------------------------------------------------

    // FSM, shifter and bit counter: load a word, step it out, chain the next one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_shift   <= '0;
            r_bit_cnt <= '0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    // Shifter empty: an accepted word goes straight into it so
                    // its first bit is valid on the very next cycle.
                    if (w_xfer) begin
                        r_shift   <= din;
                        r_bit_cnt <= '0;
                        r_state   <= c_st_shift;
                    end
                end
                c_st_shift: begin
                    if (w_last) begin
                        // Chain the following word with no bubble. A parked
                        // word has priority; din_ready is low in that case,
                        // so the two sources can never both be present.
                        r_bit_cnt <= '0;
                        if (r_hold_full) begin
                            r_shift <= r_hold;
                        end else if (w_xfer) begin
                            r_shift <= din;
                        end else begin
                            r_shift <= '0;
                            r_state <= c_st_idle;
                        end
                    end else if (w_consume) begin
                        r_shift   <= w_shift_next;
                        r_bit_cnt <= r_bit_cnt + c_cnt_one;
                    end
                end
                default: begin
                    r_state   <= c_st_idle;
                    r_shift   <= '0;
                    r_bit_cnt <= '0;
                end
            endcase
        end
    end

    // Holding register: captures a word that arrives while the shifter is
    // still busy with a word that is not ending this cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else if (w_last && r_hold_full) begin
            r_hold_full <= 1'b0;
        end else if (w_xfer && w_shifting && !w_last) begin
            r_hold      <= din;
            r_hold_full <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_bit_serializer_piso.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bit_serializer_piso
//  Brief    : Self-checking bench. Two instances (MSB-first and LSB-first)
//             share all inputs; a queue-based model predicts every output.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bit_serializer_piso;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_valid = 1'b0;
    logic       bit_en = 1'b0;

    logic rdy_m, bo_m, bv_m, wd_m, busy_m;
    logic rdy_l, bo_l, bv_l, wd_l, busy_l;

    int checks   = 0;
    int failures = 0;

    // Reference model: pending bits of the current word in emission order,
    // plus the parked word.
    bit         q_m[$];
    bit         q_l[$];
    logic [7:0] m_hold;
    bit         m_hold_full;

    // Bits actually taken from each DUT, and statistics for the directed tests.
    bit seen_m[$];
    bit seen_l[$];
    int n_done;
    int n_valid;

    always #5 clk = ~clk;

    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_m),
        .bit_en(bit_en), .bit_out(bo_m), .bit_valid(bv_m), .word_done(wd_m), .busy(busy_m)
    );

    bit_serializer_piso #(.WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(rdy_l),
        .bit_en(bit_en), .bit_out(bo_l), .bit_valid(bv_l), .word_done(wd_l), .busy(busy_l)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_load(input logic [7:0] d);
        for (int i = 0; i < 8; i++) begin
            q_m.push_back(d[7-i]);
            q_l.push_back(d[i]);
        end
    endtask

    task automatic model_clear();
        q_m.delete();
        q_l.delete();
        m_hold      = 8'h00;
        m_hold_full = 1'b0;
    endtask

    // First-in bit lands in the MSB of the packed result.
    function automatic logic [15:0] pack(input bit use_lsb_dut);
        logic [15:0] w = 16'h0000;
        if (use_lsb_dut) foreach (seen_l[i]) w = {w[14:0], seen_l[i]};
        else             foreach (seen_m[i]) w = {w[14:0], seen_m[i]};
        return w;
    endfunction

    task automatic clear_stats();
        seen_m.delete();
        seen_l.delete();
        n_done  = 0;
        n_valid = 0;
    endtask

    // One clock: drive inputs, compare every output against the model, advance model.
    task automatic cycle(input logic [7:0] d, input logic v, input logic e);
        bit had, xfer, last, exp_m, exp_l;
        @(negedge clk);
        din = d; din_valid = v; bit_en = e;
        #1;
        had   = (q_m.size() > 0);
        exp_m = had ? q_m[0] : 1'b0;
        exp_l = had ? q_l[0] : 1'b0;
        xfer  = v && !m_hold_full;
        last  = had && e && (q_m.size() == 1);

        chk("msb_bit_valid", 16'(bv_m),   16'(had));
        chk("msb_bit_out",   16'(bo_m),   16'(exp_m));
        chk("msb_word_done", 16'(wd_m),   16'(last));
        chk("msb_din_ready", 16'(rdy_m),  16'(!m_hold_full));
        chk("msb_busy",      16'(busy_m), 16'(had || m_hold_full));
        chk("lsb_bit_valid", 16'(bv_l),   16'(had));
        chk("lsb_bit_out",   16'(bo_l),   16'(exp_l));
        chk("lsb_word_done", 16'(wd_l),   16'(last));
        chk("lsb_din_ready", 16'(rdy_l),  16'(!m_hold_full));
        chk("lsb_busy",      16'(busy_l), 16'(had || m_hold_full));

        if (bv_m && e) begin seen_m.push_back(bo_m); n_valid++; end
        if (bv_l && e) seen_l.push_back(bo_l);
        if (wd_m) n_done++;

        if (had && e) begin
            void'(q_m.pop_front());
            void'(q_l.pop_front());
        end
        if (!had) begin
            if (xfer) model_load(d);
        end else if (last) begin
            if (m_hold_full) begin
                model_load(m_hold);
                m_hold_full = 1'b0;
            end else if (xfer) begin
                model_load(d);
            end
        end else if (xfer) begin
            m_hold      = d;
            m_hold_full = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_bv_m"},   16'(bv_m),   16'h0);
        chk({tag, "_bo_m"},   16'(bo_m),   16'h0);
        chk({tag, "_wd_m"},   16'(wd_m),   16'h0);
        chk({tag, "_busy_m"}, 16'(busy_m), 16'h0);
        chk({tag, "_rdy_m"},  16'(rdy_m),  16'h1);
        chk({tag, "_bv_l"},   16'(bv_l),   16'h0);
        chk({tag, "_busy_l"}, 16'(busy_l), 16'h0);
        chk({tag, "_rdy_l"},  16'(rdy_l),  16'h1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; din_valid = 1'b0; bit_en = 1'b0;
        #1;
        check_reset_outputs("reset");
        model_clear();
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int          det_obs;
        int          det_exp;
        logic [3:0]  win;
        logic [15:0] stream;

        // ---------------- Test 1: single word 8'h5A ----------------
        do_reset();
        clear_stats();
        cycle(8'h5A, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(8'($urandom), 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("t1_bits",  pack(1'b0), 16'h005A);
        chk("t1_done",  16'(n_done), 16'd1);

        // ---------------- Test 2: back-to-back 0A, 05 ----------------
        clear_stats();
        cycle(8'h0A, 1'b1, 1'b1);
        cycle(8'h05, 1'b1, 1'b1);
        for (int i = 0; i < 15; i++) cycle(8'($urandom), 1'b0, 1'b1);
        chk("t2_contiguous", 16'(n_valid), 16'd16);
        cycle(8'h00, 1'b0, 1'b1);
        chk("t2_bits",  pack(1'b0), 16'h0A05);
        chk("t2_done",  16'(n_done), 16'd2);

        // ---------------- Test 3: stalled consume on 8'hF0 ----------------
        clear_stats();
        cycle(8'hF0, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(8'($urandom), 1'b0, (i % 2) == 0);
        cycle(8'h00, 1'b0, 1'b1);
        chk("t3_bits", pack(1'b0), 16'h00F0);
        chk("t3_done", 16'(n_done), 16'd1);

        // ---------------- Test 4: LSB-first order on 8'h01 ----------------
        clear_stats();
        cycle(8'h01, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(8'h00, 1'b0, 1'b1);
        chk("t4_lsb_order", pack(1'b1), 16'h0080);
        chk("t4_msb_order", pack(1'b0), 16'h0001);

        // ---------------- Test 5: reset mid-word with hold occupied ----------------
        cycle(8'h5A, 1'b1, 1'b1);
        cycle(8'hC3, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(8'h00, 1'b0, 1'b1);
        chk("t5_pre_busy", 16'(busy_m), 16'h1);
        do_reset();
        clear_stats();
        cycle(8'hFF, 1'b1, 1'b1);
        for (int i = 0; i < 8; i++) cycle(8'h00, 1'b0, 1'b1);
        cycle(8'h00, 1'b0, 1'b1);
        chk("t5_bits", pack(1'b0), 16'h00FF);
        chk("t5_done", 16'(n_done), 16'd1);

        // ---------------- Test 6: 0101 detections on stream 05,0A ----------------
        clear_stats();
        cycle(8'h05, 1'b1, 1'b1);
        cycle(8'h0A, 1'b1, 1'b1);
        for (int i = 0; i < 16; i++) cycle(8'h00, 1'b0, 1'b1);
        det_obs = 0;
        win     = 4'h0;
        foreach (seen_m[i]) begin
            win = {win[2:0], seen_m[i]};
            if (i >= 3 && win == 4'b0101) det_obs++;
        end
        stream  = 16'h050A;
        det_exp = 0;
        for (int i = 0; i <= 12; i++) if (((stream >> (12 - i)) & 16'hF) == 16'h5) det_exp++;
        chk("t6_detect_model", 16'(det_obs), 16'(det_exp));
        chk("t6_detect_count", 16'(det_obs), 16'd2);

        // ---------------- Randomised traffic ----------------
        do_reset();
        for (int i = 0; i < 400; i++)
            cycle(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
        for (int i = 0; i < 30; i++) cycle(8'h00, 1'b0, 1'b1);
        chk("rand_drained_busy", 16'(busy_m), 16'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
